// File: rtl/seg_pkg.sv
// Shared types and constants for the 7-segment display path.
// Glyphs are active-high {g,f,e,d,c,b,a}; invert for common-anode segment pins.
package seg_pkg;

    localparam int BCD_W = 4;
    localparam int SEG_W = 7;
    localparam logic ANODE_OFF = 1'b1;

    typedef logic [BCD_W-1:0] bcd_t;
    typedef logic [SEG_W-1:0] seg_t;

    localparam seg_t SEG_0   = 7'h3F;
    localparam seg_t SEG_1   = 7'h06;
    localparam seg_t SEG_2   = 7'h5B;
    localparam seg_t SEG_3   = 7'h4F;
    localparam seg_t SEG_4   = 7'h66;
    localparam seg_t SEG_5   = 7'h6D;
    localparam seg_t SEG_6   = 7'h7D;
    localparam seg_t SEG_7   = 7'h07;
    localparam seg_t SEG_8   = 7'h7F;
    localparam seg_t SEG_9   = 7'h6F;
    localparam seg_t SEG_ERR = 7'h79;

    function automatic seg_t bcd_to_seg(bcd_t d);
        seg_t s;
        case (d)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_ERR;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seg_prescaler.sv
// Slot cycle counter; flags describe the cycle the next clock edge produces.
module seg_prescaler
    import seg_pkg::*;
#(
    parameter int PRESCALE     = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    output logic slot_start,
    output logic blank,
    output logic slot_end
);

    localparam int CW = $clog2(PRESCALE + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        slot_start = (cnt_q == '0);
        slot_end   = (cnt_q == CW'(PRESCALE - 1));
        blank      = (int'(cnt_q) < BLANK_CYCLES);
        cnt_d      = slot_end ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/seg_scan_mux.sv
// Time-multiplexed common-anode 7-segment scanner with double-buffered digits,
// dead-time between slots and optional leading-zero blanking.
module seg_scan_mux
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int PRESCALE     = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [BCD_W*NUM_DIGITS-1:0] digits_i,
    input  logic                        load_i,
    input  logic                        lz_en_i,
    output logic [BCD_W-1:0]            bcd_o,
    output logic [NUM_DIGITS-1:0]       an_o,
    output logic                        frame_o,
    output logic                        err_o
);

    localparam int IW = $clog2(NUM_DIGITS);

    logic slot_start, blank, slot_end;

    seg_prescaler #(
        .PRESCALE     (PRESCALE),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_prescaler (
        .clk        (clk),
        .rst        (rst),
        .slot_start (slot_start),
        .blank      (blank),
        .slot_end   (slot_end)
    );

    bcd_t [NUM_DIGITS-1:0] pend_q, pend_d;
    bcd_t [NUM_DIGITS-1:0] act_q, act_d;
    logic [IW-1:0]         idx_q, idx_d;
    bcd_t                  bcd_q, bcd_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic                  frame_q, frame_d;
    logic                  err_q, err_d;
    logic                  upper_nz, lz_blank;

    always_comb begin
        pend_d = load_i ? digits_i : pend_q;
        act_d  = act_q;
        // Frame boundary: a same-cycle load bypasses pending so it is not lost a frame
        if (slot_start && idx_q == '0)
            act_d = load_i ? digits_i : pend_q;
        idx_d = idx_q;
        if (slot_end)
            idx_d = (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + IW'(1);
        upper_nz = 1'b0;
        err_d    = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (act_d[i] > bcd_t'(9)) err_d = 1'b1;
            if (i >= int'(idx_q) && act_d[i] != '0) upper_nz = 1'b1;
        end
        lz_blank = lz_en_i && (idx_q != '0) && !upper_nz;
        an_d = {NUM_DIGITS{ANODE_OFF}};
        if (!blank && !lz_blank) an_d[idx_q] = ~ANODE_OFF;
        bcd_d   = slot_start ? act_d[idx_q] : bcd_q;
        frame_d = slot_start && (idx_q == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q  <= '0;
            act_q   <= '0;
            idx_q   <= '0;
            bcd_q   <= '0;
            an_q    <= {NUM_DIGITS{ANODE_OFF}};
            frame_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            pend_q  <= pend_d;
            act_q   <= act_d;
            idx_q   <= idx_d;
            bcd_q   <= bcd_d;
            an_q    <= an_d;
            frame_q <= frame_d;
            err_q   <= err_d;
        end
    end

    assign bcd_o   = bcd_q;
    assign an_o    = an_q;
    assign frame_o = frame_q;
    assign err_o   = err_q;

endmodule
